dsa_seq_ctrl: RTL and testbench

Top-level sequencer for the digital-signature datapath: SHA3 core, two AES halves (MSB/LSB) and the verification/output stage.
- Accepts a sign (encrypt) or verify (decrypt) command and streams in 64-bit operand beats.
- Launches the cores, tracks their done flags, counts the verification stage's valid beats and reports result/timeout.
- Resets the cores and the verification stage between commands.

---
 rtl/dsa_pkg.sv | 39 +++
 rtl/dsa_beat_loader.sv | 62 ++++++
 rtl/dsa_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dsa_seq_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsa_pkg.sv
// Shared types and constants for the digital-signature sequencer: FSM encoding,
// beat counts, mode values and the operand-buffer slot mapping.
package dsa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_COLLECT = 3'd4,
        ST_CLEAR   = 3'd5
    } state_e;

    typedef struct packed {
        logic sha;
        logic msb;
        logic lsb;
    } done_flags_t;

    localparam int ENC_BEATS       = 4;
    localparam int DEC_BEATS       = 8;
    localparam int ENC_VALID_BEATS = 4;
    localparam int BUF_WORDS       = 8;
    localparam int BEAT_CNT_BW     = 3;
    localparam int VCNT_BW         = 3;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Buffer words 0-3 hold the SHA3 message and 4-7 the AES operand (word 0 is
    // the most significant); encrypt beats skip straight to the AES words.
    function automatic logic [BEAT_CNT_BW-1:0] beat_slot(input logic mode,
                                                         input logic [BEAT_CNT_BW-1:0] cnt);
        if (mode == MODE_DEC)
            return cnt;
        return cnt + BEAT_CNT_BW'(DEC_BEATS - ENC_BEATS);
    endfunction

endpackage

// File: rtl/dsa_beat_loader.sv
// Operand loader: counts accepted beats and steers each one into its 64-bit
// word of the 512-bit operand buffer; flags the last beat of the command.
module dsa_beat_loader
    import dsa_pkg::*;
#(
    parameter int DATA_BW = 64
) (
    input  logic                           clk,
    input  logic                           srst_n,
    input  logic                           clear_i,
    input  logic                           load_en_i,
    input  logic                           mode_i,
    input  logic                           in_valid_i,
    input  logic [DATA_BW-1:0]             in_data_i,
    output logic                           in_ready_o,
    output logic                           last_beat_o,
    output logic [BUF_WORDS*DATA_BW-1:0]   buf_o
);

    logic [BEAT_CNT_BW-1:0] beat_cnt_q;
    logic [BEAT_CNT_BW-1:0] beat_cnt_d;
    logic [BEAT_CNT_BW-1:0] last_idx;
    logic [BEAT_CNT_BW-1:0] slot;
    logic                   wr_en;
    logic [DATA_BW-1:0]     word_q [BUF_WORDS];

    assign in_ready_o  = load_en_i;
    assign wr_en       = load_en_i & in_valid_i;
    assign last_idx    = (mode_i == MODE_DEC) ? BEAT_CNT_BW'(DEC_BEATS - 1)
                                              : BEAT_CNT_BW'(ENC_BEATS - 1);
    assign last_beat_o = wr_en & (beat_cnt_q == last_idx);
    assign slot        = beat_slot(mode_i, beat_cnt_q);

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (clear_i)
            beat_cnt_d = '0;
        else if (wr_en)
            beat_cnt_d = beat_cnt_q + BEAT_CNT_BW'(1);
    end

    always_ff @(posedge clk) begin
        if (!srst_n)
            beat_cnt_q <= '0;
        else
            beat_cnt_q <= beat_cnt_d;
    end

    // Words only change on a write, so the operands stay stable between loads.
    generate
        for (genvar gi = 0; gi < BUF_WORDS; gi++) begin : g_word
            always_ff @(posedge clk) begin
                if (!srst_n)
                    word_q[gi] <= '0;
                else if (wr_en && (slot == BEAT_CNT_BW'(gi)))
                    word_q[gi] <= in_data_i;
            end
            assign buf_o[(BUF_WORDS-gi)*DATA_BW-1 -: DATA_BW] = word_q[gi];
        end
    endgenerate

endmodule

// File: rtl/dsa_seq_ctrl.sv
// Digital-signature sequencer: loads operands, launches SHA3/AES, waits for all
// required done flags, collects verification beats and reports result/timeout.
module dsa_seq_ctrl
    import dsa_pkg::*;
#(
    parameter int DATA_BW     = 64,
    parameter int SHA_DATA_BW = 256,
    parameter int AES_TXT_BW  = 128,
    parameter int TO_BW       = 10
) (
    input  logic                   clk,
    input  logic                   srst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_BW-1:0]     in_data,
    output logic                   sha3_start,
    output logic [SHA_DATA_BW-1:0] sha3_msg,
    input  logic                   sha3_done,
    output logic                   aes_start,
    output logic                   aes_mode,
    output logic [AES_TXT_BW-1:0]  aes_msb_i,
    output logic [AES_TXT_BW-1:0]  aes_lsb_i,
    input  logic                   aes_msb_done,
    input  logic                   aes_lsb_done,
    input  logic                   vrfy_valid,
    input  logic                   vrfy_verify,
    output logic                   sub_srst_n,
    output logic                   busy,
    output logic                   done,
    output logic                   result,
    output logic                   err_timeout
);

    localparam int BUF_BW = BUF_WORDS * DATA_BW;
    localparam logic [TO_BW-1:0] TO_MAX = '1;

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic                  result_q, result_d;
    logic                  err_q, err_d;
    done_flags_t           flags_q, flags_d;
    logic [TO_BW-1:0]      to_cnt_q, to_cnt_d;
    logic [VCNT_BW-1:0]    vcnt_q, vcnt_d;
    logic                  load_clr;
    logic                  load_en;
    logic                  last_beat;
    logic                  req_met;
    logic [BUF_BW-1:0]     op_buf;

    assign load_en = (state_q == ST_LOAD);

    dsa_beat_loader #(
        .DATA_BW (DATA_BW)
    ) u_loader (
        .clk         (clk),
        .srst_n      (srst_n),
        .clear_i     (load_clr),
        .load_en_i   (load_en),
        .mode_i      (mode_q),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .last_beat_o (last_beat),
        .buf_o       (op_buf)
    );

    assign sha3_msg  = op_buf[BUF_BW-1 -: SHA_DATA_BW];
    assign aes_msb_i = op_buf[2*AES_TXT_BW-1 -: AES_TXT_BW];
    assign aes_lsb_i = op_buf[AES_TXT_BW-1:0];

    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_CLEAR);
    assign aes_start   = (state_q == ST_START);
    assign sha3_start  = (state_q == ST_START) && (mode_q == MODE_DEC);
    assign aes_mode    = mode_q;
    assign sub_srst_n  = srst_n & ~(state_q == ST_CLEAR);
    assign result      = result_q;
    assign err_timeout = err_q;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        result_d = result_q;
        err_d    = err_q;
        flags_d  = flags_q;
        to_cnt_d = to_cnt_q;
        vcnt_d   = vcnt_q;
        load_clr = 1'b0;
        req_met  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    mode_d   = cmd_mode;
                    result_d = 1'b0;
                    err_d    = 1'b0;
                    load_clr = 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (last_beat)
                    state_d = ST_START;
            end
            ST_START: begin
                flags_d  = '0;
                to_cnt_d = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                // Include this cycle's done inputs so a completing pulse exits now.
                flags_d.sha = flags_q.sha | sha3_done;
                flags_d.msb = flags_q.msb | aes_msb_done;
                flags_d.lsb = flags_q.lsb | aes_lsb_done;
                req_met = flags_d.msb & flags_d.lsb & ((mode_q == MODE_ENC) | flags_d.sha);
                if (req_met) begin
                    to_cnt_d = '0;
                    vcnt_d   = '0;
                    state_d  = ST_COLLECT;
                end else if (to_cnt_q == TO_MAX) begin
                    err_d    = 1'b1;
                    result_d = 1'b0;
                    state_d  = ST_CLEAR;
                end else begin
                    to_cnt_d = to_cnt_q + TO_BW'(1);
                end
            end
            ST_COLLECT: begin
                if (vrfy_valid && (mode_q == MODE_DEC)) begin
                    result_d = vrfy_verify;
                    state_d  = ST_CLEAR;
                end else if (vrfy_valid && (vcnt_q == VCNT_BW'(ENC_VALID_BEATS - 1))) begin
                    result_d = 1'b0;
                    state_d  = ST_CLEAR;
                end else if (to_cnt_q == TO_MAX) begin
                    err_d    = 1'b1;
                    result_d = 1'b0;
                    state_d  = ST_CLEAR;
                end else begin
                    to_cnt_d = to_cnt_q + TO_BW'(1);
                    if (vrfy_valid)
                        vcnt_d = vcnt_q + VCNT_BW'(1);
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_ENC;
            result_q <= 1'b0;
            err_q    <= 1'b0;
            flags_q  <= '0;
            to_cnt_q <= '0;
            vcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            err_q    <= err_d;
            flags_q  <= flags_d;
            to_cnt_q <= to_cnt_d;
            vcnt_q   <= vcnt_d;
        end
    end

endmodule

// File: tb/tb_dsa_seq_ctrl.sv
// Bench for dsa_seq_ctrl: directed and randomized commands checked against a
// transaction-level model of operand placement, pulse counts and latencies.
module tb_dsa_seq_ctrl;

    logic         clk = 1'b0;
    logic         srst_n;
    logic         cmd_valid, cmd_ready, cmd_mode;
    logic         in_valid, in_ready;
    logic [63:0]  in_data;
    logic         sha3_start, sha3_done, aes_start, aes_mode;
    logic [255:0] sha3_msg;
    logic [127:0] aes_msb_i, aes_lsb_i;
    logic         aes_msb_done, aes_lsb_done, vrfy_valid, vrfy_verify;
    logic         sub_srst_n, busy, done, result, err_timeout;

    int checks = 0;
    int failures = 0;
    int n_aes, n_sha, n_done, n_subrst;

    logic [63:0]  bt [8];
    logic [255:0] exp_sha;
    logic [127:0] exp_msb, exp_lsb;

    dsa_seq_ctrl dut (
        .clk(clk), .srst_n(srst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .sha3_start(sha3_start), .sha3_msg(sha3_msg), .sha3_done(sha3_done),
        .aes_start(aes_start), .aes_mode(aes_mode),
        .aes_msb_i(aes_msb_i), .aes_lsb_i(aes_lsb_i),
        .aes_msb_done(aes_msb_done), .aes_lsb_done(aes_lsb_done),
        .vrfy_valid(vrfy_valid), .vrfy_verify(vrfy_verify),
        .sub_srst_n(sub_srst_n), .busy(busy), .done(done),
        .result(result), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        if (aes_start) n_aes++;
        if (sha3_start) n_sha++;
        if (done) n_done++;
        if (srst_n && !sub_srst_n) n_subrst++;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_operands(input string tag);
        chkw({tag, "_sha3_msg"}, sha3_msg, exp_sha);
        chkw({tag, "_aes_msb"}, {128'd0, aes_msb_i}, {128'd0, exp_msb});
        chkw({tag, "_aes_lsb"}, {128'd0, aes_lsb_i}, {128'd0, exp_lsb});
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Model: encrypt words land on the AES operand, decrypt fills SHA3 then AES.
    task automatic model_load(input bit mode);
        if (mode) begin
            exp_sha = {bt[0], bt[1], bt[2], bt[3]};
            exp_msb = {bt[4], bt[5]};
            exp_lsb = {bt[6], bt[7]};
        end else begin
            exp_msb = {bt[0], bt[1]};
            exp_lsb = {bt[2], bt[3]};
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk1({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_in_ready"}, in_ready, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_result"}, result, 1'b0);
        chk1({tag, "_err"}, err_timeout, 1'b0);
        chk1({tag, "_aes_start"}, aes_start, 1'b0);
        chk1({tag, "_sub_srst_n"}, sub_srst_n, 1'b0);
        chk_operands(tag);
    endtask

    task automatic run_op(input bit mode, input bit verify, input bit lsb_never,
                          input int d_msb, input int d_lsb, input int d_sha, input bit gaps);
        int nb;
        int last;
        int n;
        logic exp_res;
        nb = mode ? 8 : 4;
        n_aes = 0; n_sha = 0; n_done = 0; n_subrst = 0;
        chk1("idle_cmd_ready", cmd_ready, 1'b1);
        // Command accept; a stray beat offered in IDLE must be ignored.
        cmd_valid = 1'b1; cmd_mode = mode; in_valid = 1'b1; in_data = rnd64();
        tick();
        cmd_mode = ~mode;
        in_valid = 1'b0;
        chk1("load_busy", busy, 1'b1);
        chk1("load_in_ready", in_ready, 1'b1);
        chk1("load_cmd_ready", cmd_ready, 1'b0);
        chk1("accept_clears_err", err_timeout, 1'b0);
        chk1("accept_clears_result", result, 1'b0);
        for (int i = 0; i < nb; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0; in_data = rnd64();
                tick();
                chk1("gap_in_ready", in_ready, 1'b1);
            end
            in_valid = 1'b1; in_data = bt[i];
            tick();
        end
        in_data = rnd64();
        model_load(mode);
        chk1("start_aes_start", aes_start, 1'b1);
        chk1("start_sha3_start", sha3_start, mode);
        chk1("start_aes_mode", aes_mode, mode);
        chk1("start_in_ready", in_ready, 1'b0);
        chk_operands("start");
        tick();
        if (lsb_never) begin
            n = 0;
            while (!done && n < 1100) begin
                sha3_done = (n == d_sha); aes_msb_done = (n == d_msb); aes_lsb_done = 1'b0;
                tick();
                n++;
            end
            sha3_done = 1'b0; aes_msb_done = 1'b0;
            chkn("timeout_wait_cycles", n, 1024);
            chk1("timeout_err", err_timeout, 1'b1);
            exp_res = 1'b0;
        end else begin
            last = (d_msb > d_lsb) ? d_msb : d_lsb;
            if (mode && d_sha > last) last = d_sha;
            for (int c = 0; c <= last; c++) begin
                sha3_done = (c == d_sha); aes_msb_done = (c == d_msb); aes_lsb_done = (c == d_lsb);
                vrfy_valid = 1'b1; vrfy_verify = ~verify;
                tick();
                chk1("wait_no_done", done, 1'b0);
            end
            sha3_done = 1'b0; aes_msb_done = 1'b0; aes_lsb_done = 1'b0;
            if (mode) begin
                vrfy_valid = 1'b1; vrfy_verify = verify;
                tick();
                exp_res = verify;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        vrfy_valid = 1'b0;
                        tick();
                        chk1("collect_gap_no_done", done, 1'b0);
                    end
                    vrfy_valid = 1'b1; vrfy_verify = 1'($urandom);
                    tick();
                    if (k < 3) chk1("collect_no_done", done, 1'b0);
                end
                exp_res = 1'b0;
            end
            chk1("clear_err", err_timeout, 1'b0);
        end
        vrfy_valid = 1'b0; cmd_valid = 1'b0; in_valid = 1'b0;
        chk1("clear_done", done, 1'b1);
        chk1("clear_sub_srst_n", sub_srst_n, 1'b0);
        chk1("clear_result", result, exp_res);
        tick();
        chk1("idle_done_low", done, 1'b0);
        chk1("idle_sub_srst_n", sub_srst_n, 1'b1);
        chk1("idle_cmd_ready_after", cmd_ready, 1'b1);
        chk1("idle_result_held", result, exp_res);
        chk1("idle_err_held", err_timeout, lsb_never);
        chk_operands("idle_stable");
        chkn("aes_start_pulses", n_aes, 1);
        chkn("sha3_start_pulses", n_sha, mode ? 1 : 0);
        chkn("done_pulses", n_done, 1);
        chkn("sub_reset_cycles", n_subrst, 1);
        $display("op mode=%0d verify=%0d timeout=%0d dly=%0d/%0d/%0d result=%0d err=%0d",
                 mode, verify, lsb_never, d_msb, d_lsb, d_sha, result, err_timeout);
    endtask

    task automatic reset_mid(input bit in_wait);
        cmd_valid = 1'b1; cmd_mode = 1'b0;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < (in_wait ? 4 : 2); i++) begin
            in_valid = 1'b1; in_data = rnd64();
            tick();
        end
        in_valid = 1'b0;
        if (in_wait) begin
            tick(); tick(); tick();
        end
        chk1("pre_reset_busy", busy, 1'b1);
        srst_n = 1'b0;
        tick();
        exp_sha = '0; exp_msb = '0; exp_lsb = '0;
        check_reset_state(in_wait ? "rst_wait" : "rst_load");
        srst_n = 1'b1;
        tick();
        chk1("post_reset_sub_srst_n", sub_srst_n, 1'b1);
        chk1("post_reset_cmd_ready", cmd_ready, 1'b1);
        $display("reset mid-%s checked", in_wait ? "WAIT" : "LOAD");
    endtask

    task automatic rand_beats();
        for (int i = 0; i < 8; i++) bt[i] = rnd64();
    endtask

    initial begin
        srst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 1'b0; in_valid = 1'b0; in_data = '0;
        sha3_done = 1'b0; aes_msb_done = 1'b0; aes_lsb_done = 1'b0;
        vrfy_valid = 1'b0; vrfy_verify = 1'b0;
        exp_sha = '0; exp_msb = '0; exp_lsb = '0;
        n_aes = 0; n_sha = 0; n_done = 0; n_subrst = 0;
        tick(); tick();
        check_reset_state("reset");
        srst_n = 1'b1;
        tick();

        bt[0] = 64'h1111_1111_1111_1111; bt[1] = 64'h2222_2222_2222_2222;
        bt[2] = 64'h3333_3333_3333_3333; bt[3] = 64'h4444_4444_4444_4444;
        run_op(1'b0, 1'b0, 1'b0, 5, 5, 0, 1'b0);

        rand_beats();
        run_op(1'b1, 1'b1, 1'b0, 3, 4, 1, 1'b1);
        rand_beats();
        run_op(1'b1, 1'b0, 1'b0, 3, 4, 1, 1'b0);
        rand_beats();
        run_op(1'b1, 1'b1, 1'b0, 0, 3, 3, 1'b1);
        rand_beats();
        run_op(1'b1, 1'b0, 1'b0, 2, 2, 2, 1'b0);

        rand_beats();
        run_op(1'b0, 1'b0, 1'b1, 2, 0, 0, 1'b0);
        rand_beats();
        run_op(1'b0, 1'b0, 1'b0, 1, 0, 0, 1'b1);

        reset_mid(1'b0);
        rand_beats();
        run_op(1'b0, 1'b0, 1'b0, 2, 3, 0, 1'b0);
        reset_mid(1'b1);
        rand_beats();
        run_op(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1);

        for (int r = 0; r < 8; r++) begin
            rand_beats();
            run_op(1'($urandom), 1'($urandom), 1'b0, $urandom_range(0, 6),
                   $urandom_range(0, 6), $urandom_range(0, 6), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
